// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (FSM states, frame shape, divider maths) for the rx and tx sides.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state_t enum, 8N1 frame constants, calc_divider() clocks-per-bit helper.
package uart_pkg;

  // 2-bit FSM encoding shared by receiver and transmitter.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTBIT = 2'd1,
    DATABIT  = 2'd2,
    STOPBIT  = 2'd3
  } state_t;

  // 8N1 framing.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clocks per bit, integer division (truncates).
  function automatic logic [31:0] calc_divider(input logic [31:0] freq,
                                               input logic [31:0] speed);
    return freq / speed;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose : 2-flop synchroniser for the async serial line plus registered falling-edge detector.
// Latency : rx_s lags rx_i by 2 clocks; fall_p is high for one clock, aligned with the first low rx_s.
// Backpressure: none, free-running.
// Ports   : clk_i, reset (async, active-high), rx_i (async line) -> rx_s (synchronised), fall_p (edge pulse).
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s,
  output logic fall_p
);

  logic meta_q;
  logic sync_q;
  logic fall_q;

  // Flops reset to 1 (idle line level) so reset release never looks like a start edge.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      // Registered so the pulse coincides with the cycle sync_q first reads low.
      fall_q <= sync_q & ~meta_q;
    end
  end

  assign rx_s   = sync_q;
  assign fall_p = fall_q;

endmodule

// File: rtl/uart_fsm_rx.sv
// Purpose : 8N1 UART receiver; re-centres on each start edge, checks start/stop bits, emits bytes.
// Latency : valid_o/frame_err_o one clock after the stop sample (edge detect + HALF + 9*DIVIDER clocks).
// Backpressure: none; the consumer must take data_o on the valid_o strobe.
// Ports   : clk_i, reset (async, active-high), rx_i (async line) -> data_o[7:0], valid_o, frame_err_o, busy_o.
module uart_fsm_rx
  import uart_pkg::*;
#(
  parameter logic [31:0] FREQUENCY = 32'd50_000_000,
  parameter logic [31:0] SPEED     = 32'd1_500_000
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam logic [31:0] DIVIDER = calc_divider(FREQUENCY, SPEED);
  localparam logic [31:0] HALF    = DIVIDER / 32'd2;

  if (DIVIDER < 32'd2) begin : g_bad_divider
    $error("uart_fsm_rx: FREQUENCY/SPEED must be at least 2");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("uart_fsm_rx: only one stop bit is supported");
  end

  logic rx_s;
  logic fall_p;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .reset  (reset),
    .rx_i   (rx_i),
    .rx_s   (rx_s),
    .fall_p (fall_p)
  );

  state_t                 state_q, state_d;
  logic [31:0]            tick_counter_q, tick_counter_d;
  logic [2:0]             bit_counter_q, bit_counter_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d;
  logic                   frame_err_d;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      tick_counter_q <= 32'd0;
      bit_counter_q  <= 3'd0;
      shreg_q        <= '0;
      data_o         <= 8'h00;
      valid_o        <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_counter_q <= tick_counter_d;
      bit_counter_q  <= bit_counter_d;
      shreg_q        <= shreg_d;
      data_o         <= data_d;
      valid_o        <= valid_d;
      frame_err_o    <= frame_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tick_counter_d = tick_counter_q;
    bit_counter_d  = bit_counter_q;
    shreg_d        = shreg_q;
    data_d         = data_o;
    valid_d        = 1'b0;
    frame_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tick_counter_d = 32'd0;
        bit_counter_d  = 3'd0;
        if (fall_p) begin
          state_d = STARTBIT;
        end
      end

      STARTBIT: begin
        // Half-bit wait puts every later sample near the bit centre.
        if (tick_counter_q == HALF - 32'd1) begin
          tick_counter_d = 32'd0;
          bit_counter_d  = 3'd0;
          // Line already back high: a glitch, not a start bit.
          state_d = rx_s ? IDLE : DATABIT;
        end else begin
          tick_counter_d = tick_counter_q + 32'd1;
        end
      end

      DATABIT: begin
        if (tick_counter_q == DIVIDER - 32'd1) begin
          tick_counter_d         = 32'd0;
          shreg_d[bit_counter_q] = rx_s;
          bit_counter_d          = bit_counter_q + 3'd1;
          if (bit_counter_q == 3'(DATA_BITS - 1)) begin
            state_d = STOPBIT;
          end
        end else begin
          tick_counter_d = tick_counter_q + 32'd1;
        end
      end

      STOPBIT: begin
        // Leaving here mid stop bit gives the next start edge half a bit of slack.
        if (tick_counter_q == DIVIDER - 32'd1) begin
          tick_counter_d = 32'd0;
          state_d        = IDLE;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          tick_counter_d = tick_counter_q + 32'd1;
        end
      end

      default: begin
        state_d        = IDLE;
        tick_counter_d = 32'd0;
        bit_counter_d  = 3'd0;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_fsm_rx.sv
// Purpose : directed table-driven bench for uart_fsm_rx at DIVIDER=8, HALF=4.
// Latency : expects busy rise 3 clocks and valid/frame_err 79 clocks after the start bit is driven.
// Backpressure: n/a.
module tb_uart_fsm_rx;

  localparam int BIT_CYC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_fsm_rx #(
    .FREQUENCY (32'd8),
    .SPEED     (32'd1)
  ) dut (
    .clk_i       (clk),
    .reset       (reset),
    .rx_i        (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse / edge monitor, sampled on the falling edge.
  int   v_cnt = 0, f_cnt = 0, both_cnt = 0;
  int   v_cyc = -1, f_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      v_cnt <= v_cnt + 1;
      v_cyc <= cyc;
    end
    if (frame_err_o === 1'b1) begin
      f_cnt <= f_cnt + 1;
      f_cyc <= cyc;
    end
    if (valid_o === 1'b1 && frame_err_o === 1'b1) both_cnt <= both_cnt + 1;
    if (busy_o === 1'b1 && !busy_prev) rise_cyc <= cyc;
    if (busy_o === 1'b0 && busy_prev) fall_cyc <= cyc;
    busy_prev <= (busy_o === 1'b1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Caller is aligned 1ns after a rising edge; each bit lasts exactly BIT_CYC clocks.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int s);
    s = cyc;
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s, v0, f0;

    vecs[0] = '{8'hA5, 1'b1, 16, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 16, 0, 1, 8'hA5};  // stop bit low
    vecs[2] = '{8'h00, 1'b1,  0, 1, 0, 8'h00};  // back-to-back with next
    vecs[3] = '{8'hFF, 1'b1, 16, 1, 0, 8'hFF};
    vecs[4] = '{8'h01, 1'b1, 16, 1, 0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 16, 1, 0, 8'h80};

    // Reset with idle line.
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data",  int'(data_o), 8'h00);
    check("rst_valid", int'(valid_o), 0);
    check("rst_ferr",  int'(frame_err_o), 0);
    check("rst_busy",  int'(busy_o), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(200);
    check("idle_valid_cnt", v_cnt, 0);
    check("idle_ferr_cnt",  f_cnt, 0);
    check("idle_busy",      int'(busy_o), 0);
    check("idle_data",      int'(data_o), 8'h00);

    // Table of frames.
    for (int i = 0; i < 6; i++) begin
      v0 = v_cnt;
      f0 = f_cnt;
      send_frame(vecs[i].dat, vecs[i].stop, s);
      check($sformatf("v%0d_valid_cnt", i), v_cnt - v0, vecs[i].exp_valid);
      check($sformatf("v%0d_ferr_cnt", i),  f_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_data", i),      int'(data_o), int'(vecs[i].exp_data));
      if (vecs[i].exp_valid != 0) check($sformatf("v%0d_valid_cyc", i), v_cyc, s + 79);
      if (vecs[i].exp_ferr != 0)  check($sformatf("v%0d_ferr_cyc", i),  f_cyc, s + 79);
      check($sformatf("v%0d_busy_rise", i), rise_cyc, s + 3);
      check($sformatf("v%0d_busy_fall", i), fall_cyc, s + 79);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end

    // Two-cycle low glitch: rejected at the start sample.
    v0 = v_cnt;
    f0 = f_cnt;
    s  = cyc;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    idle(20);
    check("glitch_busy_rise", rise_cyc, s + 3);
    check("glitch_busy_fall", fall_cyc, s + 7);
    check("glitch_valid_cnt", v_cnt - v0, 0);
    check("glitch_ferr_cnt",  f_cnt - f0, 0);
    check("glitch_data",      int'(data_o), 8'h80);

    // Reset in the middle of bit 4 of 0x55, then a clean 0x81.
    v0 = v_cnt;
    f0 = f_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midframe_busy", int'(busy_o), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  int'(busy_o), 0);
    check("abort_data",  int'(data_o), 8'h00);
    check("abort_valid", int'(valid_o), 0);
    check("abort_ferr",  int'(frame_err_o), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(24);
    check("abort_valid_cnt", v_cnt - v0, 0);
    check("abort_ferr_cnt",  f_cnt - f0, 0);
    send_frame(8'h81, 1'b1, s);
    check("after_valid_cnt", v_cnt - v0, 1);
    check("after_data",      int'(data_o), 8'h81);
    check("after_valid_cyc", v_cyc, s + 79);
    idle(10);

    check("valid_ferr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
